// File: rtl/ncl_sum_collector_if.sv
// Bundle between an NCL dual-rail counter and the clocked sum collector.
// The slave modport is the collector; the master modport is the counter plus consumer.
interface ncl_sum_collector_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] sum_t;
    logic [WIDTH-1:0] sum_f;
    logic [WIDTH-1:0] sum_ack;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      word_cnt;
    logic             rail_err;
    logic             seq_err;

    modport master (
        output sum_t, sum_f, out_ready,
        input  sum_ack, out_data, out_valid, word_cnt, rail_err, seq_err
    );

    modport slave (
        input  sum_t, sum_f, out_ready,
        output sum_ack, out_data, out_valid, word_cnt, rail_err, seq_err
    );
endinterface

// File: rtl/ncl_sum_collector.sv
// Captures dual-rail NCL sum wavefronts into a one-deep single-rail buffer.
// Rails are synchronised into clk and only stable samples drive the four-phase handshake.
module ncl_sum_collector #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                init_n,
    ncl_sum_collector_if.slave bus
);
    typedef enum logic [0:0] {StWaitData, StWaitNull} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    // Reset asserts asynchronously but leaves on a clk edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [WIDTH-1:0] t_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] f_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] t_dly_q;
    logic [WIDTH-1:0] f_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                t_sync_q[i] <= '0;
                f_sync_q[i] <= '0;
            end
            t_dly_q <= '0;
            f_dly_q <= '0;
        end else begin
            t_sync_q[0] <= bus.sum_t;
            f_sync_q[0] <= bus.sum_f;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                t_sync_q[i] <= t_sync_q[i-1];
                f_sync_q[i] <= f_sync_q[i-1];
            end
            t_dly_q <= t_sync_q[SYNC_STAGES-1];
            f_dly_q <= f_sync_q[SYNC_STAGES-1];
        end
    end

    logic [WIDTH-1:0] s_t;
    logic [WIDTH-1:0] s_f;
    logic             stable;
    logic             is_data;
    logic             is_null;
    logic             is_clash;

    assign s_t      = t_sync_q[SYNC_STAGES-1];
    assign s_f      = f_sync_q[SYNC_STAGES-1];
    // A sample is trusted only once it has survived two consecutive edges unchanged.
    assign stable   = (s_t == t_dly_q) && (s_f == f_dly_q);
    assign is_data  = stable && (&(s_t ^ s_f));
    assign is_null  = stable && !(|(s_t | s_f));
    assign is_clash = stable && (|(s_t & s_f));

    state_e           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [15:0]      word_cnt_q;
    logic             rail_err_q;
    logic             seq_err_q;
    logic             first_q;
    logic             space;
    logic             pop;

    assign space = !out_valid_q || bus.out_ready;
    assign pop   = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitData;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            rail_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            if (is_clash) begin
                rail_err_q <= 1'b1;
            end
            if (pop) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StWaitData: begin
                    // A capture in the same cycle as a pop overrides the clear above.
                    if (is_data && space) begin
                        out_data_q  <= t_dly_q;
                        out_valid_q <= 1'b1;
                        word_cnt_q  <= word_cnt_q + 16'd1;
                        first_q     <= 1'b0;
                        if (!first_q && (t_dly_q != out_data_q + One)) begin
                            seq_err_q <= 1'b1;
                        end
                        state_q <= StWaitNull;
                    end
                end
                StWaitNull: begin
                    if (is_null) begin
                        state_q <= StWaitData;
                    end
                end
                default: state_q <= StWaitData;
            endcase
        end
    end

    assign bus.sum_ack   = {WIDTH{state_q == StWaitNull}};
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.rail_err  = rail_err_q;
    assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_ncl_sum_collector.sv
// Scoreboard bench for ncl_sum_collector: stimulus queues expected words, a monitor
// compares each word as the consumer pops it.
module tb_ncl_sum_collector;
    localparam int unsigned W   = 32;
    localparam int          Lat = 4;

    logic clk    = 1'b0;
    logic init_n = 1'b0;

    always #5 clk = ~clk;

    ncl_sum_collector_if #(.WIDTH(W)) bus ();

    ncl_sum_collector #(
        .WIDTH      (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .init_n(init_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] t, input logic [31:0] f);
        bus.sum_t = t;
        bus.sum_f = f;
    endtask

    task automatic wait_ack(input string name, input logic v, input int budget);
        int i;
        i = 0;
        while (bus.sum_ack !== {W{v}} && i < budget) begin
            tick();
            i++;
        end
        check(name, bus.sum_ack, {W{v}});
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_cnt++;
        exp_q.push_back({w, exp_cnt});
    endtask

    task automatic send(input logic [31:0] w);
        expect_word(w);
        drive(w, ~w);
        wait_ack("ack_data", 1'b1, Lat);
        drive('0, '0);
        wait_ack("ack_null", 1'b0, Lat);
    endtask

    task automatic do_reset();
        tick();
        init_n = 1'b0;
        drive('0, '0);
        repeat (3) tick();
        init_n = 1'b1;
        exp_cnt = '0;
        repeat (3) tick();
    endtask

    // Monitor: a word is consumed at the edge after valid && ready is seen here.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (init_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", bus.out_data, e.data);
                    check("pop_cnt", bus.word_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] skew_w;
        logic [31:0] cur_t;
        logic [31:0] cur_f;
        int          early;
        int unsigned dly;

        bus.out_ready = 1'b0;
        drive('0, '0);
        init_n = 1'b0;
        repeat (3) tick();
        check("rst_ack", bus.sum_ack, '0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_cnt", bus.word_cnt, 0);
        check("rst_rail_err", bus.rail_err, 0);
        check("rst_seq_err", bus.seq_err, 0);
        init_n = 1'b1;
        repeat (3) tick();

        // First word into an empty buffer, consumer stalled.
        expect_word(32'h5);
        drive(32'h5, ~32'h5);
        wait_ack("ack_5", 1'b1, Lat);
        check("valid_5", bus.out_valid, 1);
        check("data_5", bus.out_data, 32'h5);
        check("cnt_5", bus.word_cnt, 1);
        drive('0, '0);
        wait_ack("null_5", 1'b0, Lat);

        // Full buffer must hold off the next acknowledge.
        expect_word(32'h6);
        drive(32'h6, ~32'h6);
        repeat (8) begin
            tick();
            check("backpressure_ack", bus.sum_ack, '0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ack_6_on_pop", bus.sum_ack, {W{1'b1}});
        check("valid_6", bus.out_valid, 1);
        check("data_6", bus.out_data, 32'h6);
        check("cnt_6", bus.word_cnt, 2);
        check("seq_6", bus.seq_err, 0);
        drive('0, '0);
        wait_ack("null_6", 1'b0, Lat);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("drained_1", exp_q.size(), 0);

        // Sequence wrap is legal; a skip is sticky.
        do_reset();
        send(32'hFFFF_FFFE);
        send(32'hFFFF_FFFF);
        send(32'h0000_0000);
        check("seq_wrap", bus.seq_err, 0);
        send(32'h0000_0002);
        check("seq_skip", bus.seq_err, 1);
        send(32'h0000_0003);
        check("seq_sticky", bus.seq_err, 1);
        check("cnt_seq", bus.word_cnt, 5);

        // Digits arrive one at a time with skew.
        skew_w = 32'hA5C3_1E74;
        cur_t  = '0;
        cur_f  = '0;
        early  = 0;
        expect_word(skew_w);
        for (int i = 0; i < 32; i++) begin
            if (skew_w[i]) cur_t[i] = 1'b1;
            else cur_f[i] = 1'b1;
            drive(cur_t, cur_f);
            if (i < 31) begin
                dly = (i == 15) ? 6 : $urandom_range(0, 2);
                repeat (dly) begin
                    tick();
                    if (bus.sum_ack !== '0) early++;
                end
            end
        end
        check("skew_no_early_ack", early, 0);
        wait_ack("skew_ack", 1'b1, Lat);
        check("skew_data", bus.out_data, skew_w);
        drive('0, '0);
        wait_ack("skew_null", 1'b0, Lat);

        // Digit 7 with both rails high.
        drive(32'h1234_5678 | 32'h80, ~32'h1234_5678 | 32'h80);
        repeat (Lat) tick();
        check("clash_rail_err", bus.rail_err, 1);
        check("clash_ack", bus.sum_ack, '0);
        check("clash_cnt", bus.word_cnt, exp_cnt);
        drive('0, '0);
        repeat (6) tick();
        check("clash_no_capture", bus.word_cnt, exp_cnt);
        check("clash_sticky", bus.rail_err, 1);
        check("drained_2", exp_q.size(), 0);

        // Reset while waiting for NULL; data stays on the rails across release.
        bus.out_ready = 1'b0;
        drive(32'h40, ~32'h40);
        wait_ack("ack_pre_reset", 1'b1, Lat);
        @(posedge clk);
        #2;
        init_n = 1'b0;
        #1;
        check("mid_rst_ack", bus.sum_ack, '0);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_cnt", bus.word_cnt, 0);
        check("mid_rst_rail_err", bus.rail_err, 0);
        check("mid_rst_seq_err", bus.seq_err, 0);
        exp_cnt = '0;
        repeat (2) tick();
        expect_word(32'h40);
        bus.out_ready = 1'b1;
        init_n = 1'b1;
        wait_ack("ack_first_after_reset", 1'b1, 8);
        check("first_unchecked", bus.seq_err, 0);
        check("first_cnt", bus.word_cnt, 1);
        drive('0, '0);
        wait_ack("null_first", 1'b0, Lat);
        send(32'h41);
        check("seq_after_reset", bus.seq_err, 0);
        repeat (3) tick();
        check("drained_3", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
